// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : RV32 immediate decoder feeding a small FIFO of decoded entries.
//               Define IMM_GEN_ZICSR_EN to decode CSR-immediate (zimm) forms.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_imm,
  output logic [2:0]               out_fmt,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int               c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]    c_depth   = (c_aw + 1)'(DEPTH);
  localparam logic [c_aw-1:0]  c_ptr_one = (c_aw)'(1);
  localparam logic [c_aw:0]    c_cnt_one = (c_aw + 1)'(1);

  localparam logic [2:0] c_fmt_i   = 3'b000;
  localparam logic [2:0] c_fmt_b   = 3'b001;
  localparam logic [2:0] c_fmt_s   = 3'b010;
  localparam logic [2:0] c_fmt_j   = 3'b011;
  localparam logic [2:0] c_fmt_u   = 3'b100;
  localparam logic [2:0] c_fmt_csr = 3'b101;
  localparam logic [2:0] c_fmt_bad = 3'b111;

  logic [63:0]     w_imm64;
  logic [2:0]      w_fmt;
  logic            w_illegal;
  logic            w_sign;
  logic            w_push;
  logic            w_pop;
  logic            w_unused_bits;

  logic [c_aw-1:0] r_wptr;
  logic [c_aw-1:0] r_rptr;
  logic [c_aw:0]   r_count;
  logic [XLEN-1:0] r_imm_mem [DEPTH];
  logic [2:0]      r_fmt_mem [DEPTH];
  logic            r_ill_mem [DEPTH];

  assign w_sign = in_instr[31];

  // Decode at full 64-bit width, then keep the low XLEN bits.
  always_comb begin
    w_fmt     = c_fmt_bad;
    w_imm64   = '0;
    w_illegal = 1'b1;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        w_fmt     = c_fmt_i;
        w_imm64   = {{52{w_sign}}, in_instr[31:20]};
        w_illegal = 1'b0;
      end
      7'b0100011: begin
        w_fmt     = c_fmt_s;
        w_imm64   = {{52{w_sign}}, in_instr[31:25], in_instr[11:7]};
        w_illegal = 1'b0;
      end
      7'b1100011: begin
        w_fmt     = c_fmt_b;
        w_imm64   = {{51{w_sign}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
        w_illegal = 1'b0;
      end
      7'b1101111: begin
        w_fmt     = c_fmt_j;
        w_imm64   = {{43{w_sign}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
        w_illegal = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        w_fmt     = c_fmt_u;
        w_imm64   = {{32{w_sign}}, in_instr[31:12], 12'b0};
        w_illegal = 1'b0;
      end
`ifdef IMM_GEN_ZICSR_EN
      7'b1110011: begin
        if (in_instr[14]) begin
          w_fmt     = c_fmt_csr;
          w_imm64   = {59'b0, in_instr[19:15]};
          w_illegal = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  // Bits not consumed in every configuration (upper imm bits when XLEN=32).
  assign w_unused_bits = ^{w_imm64, in_instr};

  assign in_ready  = (r_count < c_depth);
  assign out_valid = (r_count != '0);
  assign count     = r_count;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_ptr_one;
      if (w_pop)  r_rptr <= r_rptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: every read is gated by a non-zero count.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_imm_mem[r_wptr] <= w_imm64[XLEN-1:0];
      r_fmt_mem[r_wptr] <= w_fmt;
      r_ill_mem[r_wptr] <= w_illegal;
    end
  end

  assign out_imm     = out_valid ? r_imm_mem[r_rptr] : '0;
  assign out_fmt     = out_valid ? r_fmt_mem[r_rptr] : 3'b000;
  assign out_illegal = out_valid ? r_ill_mem[r_rptr] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// Testbench for imm_gen_pipe: a 32-bit/depth-2 and a 64-bit/depth-4 instance
// share stimulus; a queue-based reference model checks both every cycle.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm;
  logic [2:0]  a_out_fmt;
  logic [1:0]  a_count;
  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_imm;
  logic [2:0]  b_out_fmt;
  logic [2:0]  b_count;

  int n_total = 0;
  int n_pass  = 0;
  logic [67:0] qa[$];
  logic [67:0] qb[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_instr(in_instr), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
    .out_illegal(a_out_illegal), .count(a_count));

  imm_gen_pipe #(.XLEN(64), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_instr(in_instr), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
    .out_illegal(b_out_illegal), .count(b_count));

  // Reference decode: {illegal, fmt, imm64} using signed arithmetic.
  function automatic logic [67:0] ref_decode(input logic [31:0] instr);
    longint s, imm;
    logic [2:0] fmt;
    logic ill;
    s = longint'($signed(instr));
    imm = 0; fmt = 3'd7; ill = 1'b1;
    case (instr[6:0])
      7'h13, 7'h03, 7'h67: begin imm = s >>> 20; fmt = 3'd0; ill = 1'b0; end
      7'h23: begin
        imm = ((s >>> 25) << 5) | longint'(instr[11:7]); fmt = 3'd2; ill = 1'b0;
      end
      7'h63: begin
        imm = ((s >>> 31) << 12) | (longint'(instr[7]) << 11) |
              (longint'(instr[30:25]) << 5) | (longint'(instr[11:8]) << 1);
        fmt = 3'd1; ill = 1'b0;
      end
      7'h6F: begin
        imm = ((s >>> 31) << 20) | (longint'(instr[19:12]) << 12) |
              (longint'(instr[20]) << 11) | (longint'(instr[30:21]) << 1);
        fmt = 3'd3; ill = 1'b0;
      end
      7'h37, 7'h17: begin imm = s & ~longint'(64'hFFF); fmt = 3'd4; ill = 1'b0; end
`ifdef IMM_GEN_ZICSR_EN
      7'h73: if (instr[14]) begin imm = longint'(instr[19:15]); fmt = 3'd5; ill = 1'b0; end
`endif
      default: ;
    endcase
    return {ill, fmt, imm};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a queue per instance, bounded by its depth.
  always @(posedge clk or negedge rst_n) begin : model
    bit pa, pb, ra, rb;
    if (!rst_n) begin
      qa.delete(); qb.delete();
    end else if (flush) begin
      qa.delete(); qb.delete();
    end else begin
      pa = in_valid && (qa.size() < 2);
      pb = in_valid && (qb.size() < 4);
      ra = out_ready && (qa.size() != 0);
      rb = out_ready && (qb.size() != 0);
      if (ra) void'(qa.pop_front());
      if (rb) void'(qb.pop_front());
      if (pa) qa.push_back(ref_decode(in_instr));
      if (pb) qb.push_back(ref_decode(in_instr));
    end
  end

  always @(negedge clk) begin : compare
    logic [67:0] ea, eb;
    ea = (qa.size() != 0) ? qa[0] : '0;
    eb = (qb.size() != 0) ? qb[0] : '0;
    chk("a_out_valid", a_out_valid, qa.size() != 0);
    chk("a_in_ready",  a_in_ready,  qa.size() < 2);
    chk("a_count",     a_count,     qa.size());
    chk("a_out_imm",   a_out_imm,   ea[31:0]);
    chk("a_out_fmt",   a_out_fmt,   ea[66:64]);
    chk("a_out_ill",   a_out_illegal, ea[67]);
    chk("b_out_valid", b_out_valid, qb.size() != 0);
    chk("b_in_ready",  b_in_ready,  qb.size() < 4);
    chk("b_count",     b_count,     qb.size());
    chk("b_out_imm",   b_out_imm,   eb[63:0]);
    chk("b_out_fmt",   b_out_fmt,   eb[66:64]);
    chk("b_out_ill",   b_out_illegal, eb[67]);
  end

  // New inputs take effect just after a rising edge; the previous ones were
  // captured at that edge.
  task automatic drive(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    in_valid = v; in_instr = ins; out_ready = rdy; flush = fl;
  endtask

  initial begin : stim
    logic [67:0] e;
    logic [31:0] r;
    logic [6:0]  op;
    logic [6:0]  ops [9];
    int          k;
    ops = '{7'h13, 7'h03, 7'h67, 7'h63, 7'h23, 7'h6F, 7'h37, 7'h17, 7'h73};

    // Pin the reference model with hand-computed values.
    e = ref_decode(32'hFFF00093); chk("ref_i",   e, {1'b0, 3'd0, 64'hFFFFFFFFFFFFFFFF});
    e = ref_decode(32'hFE000EE3); chk("ref_b",   e, {1'b0, 3'd1, 64'hFFFFFFFFFFFFFFFC});
    e = ref_decode(32'h12345037); chk("ref_u",   e, {1'b0, 3'd4, 64'h0000000012345000});
    e = ref_decode(32'h80000037); chk("ref_u64", e, {1'b0, 3'd4, 64'hFFFFFFFF80000000});
    e = ref_decode(32'h0000007F); chk("ref_bad", e, {1'b1, 3'd7, 64'h0});

    #1 rst_n = 1'b0;
    #1;
    chk("rst_a_valid", a_out_valid, 1'b0);
    chk("rst_a_ready", a_in_ready, 1'b1);
    chk("rst_a_count", a_count, 2'd0);
    chk("rst_a_imm",   a_out_imm, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 32'hFFF00093, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("d_i_valid", a_out_valid, 1'b1);
    chk("d_i_imm",   a_out_imm, 32'hFFFFFFFF);
    chk("d_i_fmt",   a_out_fmt, 3'd0);
    drive(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
    drive(1'b1, 32'h12345037, 1'b1, 1'b0);
    chk("d_b_imm", a_out_imm, 32'hFFFFFFFC);
    chk("d_b_fmt", a_out_fmt, 3'd1);
    drive(1'b1, 32'h80000037, 1'b1, 1'b0);
    chk("d_u_imm", a_out_imm, 32'h12345000);
    chk("d_u_fmt", a_out_fmt, 3'd4);
    drive(1'b1, 32'h0000007F, 1'b1, 1'b0);
    chk("d_u64_imm", b_out_imm, 64'hFFFFFFFF80000000);
    chk("d_u64_fmt", b_out_fmt, 3'd4);
    drive(1'b1, 32'h3401D073, 1'b1, 1'b0);
    chk("d_bad_ill", a_out_illegal, 1'b1);
    chk("d_bad_fmt", a_out_fmt, 3'd7);
    chk("d_bad_imm", a_out_imm, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
`ifdef IMM_GEN_ZICSR_EN
    chk("d_csr_fmt", a_out_fmt, 3'd5);
    chk("d_csr_imm", a_out_imm, 32'h3);
    chk("d_csr_ill", a_out_illegal, 1'b0);
`else
    chk("d_csr_fmt", a_out_fmt, 3'd7);
    chk("d_csr_ill", a_out_illegal, 1'b1);
`endif
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("d_empty_cnt", a_count, 2'd0);

    // Back-pressure: three back-to-back with consumer stalled.
    drive(1'b1, 32'h00100093, 1'b0, 1'b0);
    drive(1'b1, 32'h00200093, 1'b0, 1'b0);
    drive(1'b1, 32'h00300093, 1'b0, 1'b0);
    drive(1'b1, 32'h00300093, 1'b0, 1'b0);
    chk("bp_count", a_count, 2'd2);
    chk("bp_ready", a_in_ready, 1'b0);
    chk("bp_head",  a_out_imm, 32'd1);
    drive(1'b1, 32'h00300093, 1'b1, 1'b0);
    chk("bp_hold",  a_out_imm, 32'd1);
    drive(1'b1, 32'h00300093, 1'b1, 1'b0);
    chk("bp_head2", a_out_imm, 32'd2);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_head3", a_out_imm, 32'd3);
    chk("bp_cnt3",  a_count, 2'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Flush with a full buffer and a concurrent push.
    drive(1'b1, 32'h00100093, 1'b0, 1'b0);
    drive(1'b1, 32'h00200093, 1'b0, 1'b0);
    drive(1'b1, 32'h00300093, 1'b1, 1'b1);
    chk("fl_pre_cnt", a_count, 2'd2);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("fl_count", a_count, 2'd0);
    chk("fl_valid", a_out_valid, 1'b0);

    // Asynchronous reset mid-stream.
    drive(1'b1, 32'h00100093, 1'b0, 1'b0);
    drive(1'b1, 32'h00200093, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("ar_pre_cnt", a_count, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_a_valid", a_out_valid, 1'b0);
    chk("ar_a_count", a_count, 2'd0);
    chk("ar_a_ready", a_in_ready, 1'b1);
    chk("ar_b_count", b_count, 3'd0);
    chk("ar_b_imm",   b_out_imm, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic.
    repeat (800) begin
      r  = $urandom();
      k  = $urandom_range(0, 9);
      op = (k == 9) ? r[6:0] : ops[k];
      drive($urandom_range(0, 9) < 7, {r[31:7], op},
            $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 2, output buffer entries; power of two, >=2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous clear of all buffered entries.
REQ-006 in_valid  input  1  in_instr is valid this cycle.
REQ-007 in_ready  output  1  block accepts an instruction this cycle.
REQ-008 in_instr  input  32  raw RV32 instruction word.
REQ-009 out_valid  output  1  head entry is valid.
REQ-010 out_ready  input  1  consumer takes the head entry this cycle.
REQ-011 out_imm  output  XLEN  extended immediate of head entry.
REQ-012 out_fmt  output  3  format code of head entry.
REQ-013 out_illegal  output  1  head entry carried an unsupported opcode.
REQ-014 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 Format SHALL be decoded from in_instr[6:0]: 0010011/0000011/1100111 -> I (000); 1100011 -> B (001); 0100011 -> S (010); 1101111 -> J (011); 0110111/0010111 -> U (100).
REQ-016 I: sign-ext instr[31:20]; S: sign-ext {instr[31:25],instr[11:7]}; B: sign-ext {instr[31],instr[7],instr[30:25],instr[11:8],0}; J: sign-ext {instr[31],instr[19:12],instr[20],instr[30:21],0}; U: sign-ext {instr[31:12],12'b0}.
REQ-017 All sign extension SHALL replicate instr[31] up to XLEN bits, including U when XLEN=64.
REQ-018 Any other opcode SHALL yield out_fmt=111, out_imm=0, out_illegal=1; decodable opcodes yield out_illegal=0.
REQ-019 Push occurs when in_valid && in_ready; entry (imm, fmt, illegal) SHALL be stored decoded.
REQ-020 in_ready SHALL equal (count < DEPTH), registered-state only; no combinational path from out_ready.
REQ-021 Pop occurs when out_valid && out_ready; out_valid SHALL equal (count != 0).
REQ-022 Latency: a pushed entry SHALL appear at outputs no earlier than the next cycle when the buffer was empty.
REQ-023 Order SHALL be FIFO; read/write pointers wrap modulo DEPTH.
REQ-024 Simultaneous push and pop SHALL leave count unchanged.
REQ-025 While out_valid && !out_ready, out_imm/out_fmt/out_illegal SHALL be held stable.
REQ-026 flush SHALL set count=0 and both pointers=0 next cycle, overriding same-cycle push and pop.
REQ-027 With count=0, out_imm=0, out_fmt=000, out_illegal=0.

Reset
REQ-028 rst_n low SHALL immediately clear pointers and count; out_valid=0, in_ready=1, out_imm=0, out_fmt=000, out_illegal=0, count=0.
REQ-029 Reset mid-operation SHALL discard all buffered entries; no entry survives reset.

Configuration
REQ-030 Macro IMM_GEN_ZICSR_EN defined: opcode 1110011 with instr[14]=1 SHALL decode as CSR-immediate, out_fmt=101, out_imm=zero-ext instr[19:15], out_illegal=0.
REQ-031 Macro undefined: every 1110011 encoding SHALL be treated as illegal per REQ-018.

Verification
REQ-032 XLEN=32, push 0xFFF00093 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=000.
REQ-033 Push 0xFE000EE3 -> out_imm=0xFFFFFFFC, out_fmt=001; push 0x12345037 -> out_imm=0x12345000, out_fmt=100.
REQ-034 XLEN=64, push 0x80000037 -> out_imm=0xFFFFFFFF80000000, out_fmt=100.
REQ-035 DEPTH=2, out_ready=0, present 3 instructions back-to-back -> count=2, in_ready=0, third held; raise out_ready -> FIFO order preserved, count never exceeds 2.
REQ-036 Push 0x0000007F -> out_illegal=1, out_fmt=111, out_imm=0; push 0x3401D073 -> with IMM_GEN_ZICSR_EN out_fmt=101, out_imm=3; without, out_illegal=1.
REQ-037 count=2, assert flush with in_valid=1 -> next cycle count=0, out_valid=0; assert rst_n=0 mid-stream -> outputs at reset values before next edge.
